mcs_bridge_nx: RTL and testbench

- Parametrised successor to the MCS IO-bus bridge. Converts MicroBlaze MCS IO-bus transactions inside the BRG_BASE window into the team's basic bus.
- Serves N_CS independent slave regions (mmio, video, future cores), each with its own chip-select, read-data return and ready.
- Adds slave wait states, byte-enable pass-through, bus-error reporting for unmapped accesses, and an optional timeout.
- Sits between the cpu instance and the subsystem instances in the top level.

---
 rtl/mcs_bridge_pkg.sv | 23 ++
 rtl/mcs_bridge_nx.sv | 207 ++++++++++++++++++++
 tb/tb_mcs_bridge_nx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs_bridge_pkg.sv
// Shared types, field positions and helpers for the MCS IO-bus bridge (mcs_bridge_nx).
package mcs_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int BRG_MATCH_HI = 31;
    localparam int BRG_MATCH_LO = 24;
    localparam int REGION_HI    = 23;
    localparam int REGION_LO    = 22;
    localparam int MAX_CS       = 4;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    function automatic logic [1:0] get_region(input logic [31:0] addr);
        return addr[REGION_HI:REGION_LO];
    endfunction

endpackage

// File: rtl/mcs_bridge_nx.sv
// MicroBlaze MCS IO-bus to basic-bus bridge with N_CS slave regions, wait states and error flag.
// Optional wait timeout is built when MCS_BRIDGE_TIMEOUT_EN is defined.
module mcs_bridge_nx
    import mcs_bridge_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          N_CS     = 2,
    parameter int          ADDR_W   = 21,
    parameter int          TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_addr_strobe,
    input  logic                io_read_strobe,
    input  logic                io_write_strobe,
    input  logic [3:0]          io_byte_enable,
    input  logic [31:0]         io_address,
    input  logic [31:0]         io_write_data,
    output logic [31:0]         io_read_data,
    output logic                io_ready,
    output logic [N_CS-1:0]     b_cs,
    output logic                b_wr,
    output logic                b_rd,
    output logic [3:0]          b_be,
    output logic [20:0]         b_addr,
    output logic [31:0]         b_wr_data,
    input  logic [32*N_CS-1:0]  b_rd_data,
    input  logic [N_CS-1:0]     b_ready,
    output logic                bus_err,
    input  logic                err_clr
);

    if (N_CS < 1 || N_CS > MAX_CS) begin : g_bad_n_cs
        $error("mcs_bridge_nx: N_CS out of range");
    end

    state_t             state_r, state_s;
    logic [N_CS-1:0]    b_cs_r, b_cs_s, cs_dec_s;
    logic               b_wr_r, b_wr_s, b_rd_r, b_rd_s;
    logic               write_r, write_s;
    logic [3:0]         b_be_r, b_be_s;
    logic [20:0]        b_addr_r, b_addr_s, addr_s;
    logic [31:0]        b_wr_data_r, b_wr_data_s;
    logic [31:0]        io_read_data_r, io_read_data_s, rd_sel_s;
    logic               io_ready_r, io_ready_s;
    logic               bus_err_r, bus_err_s, err_set_s;
    logic [1:0]         region_s;
    logic               hit_s, ready_sel_s, timeout_s;
    logic               unused_s;

    // The read strobe is implied by the absence of a write strobe; low address bits are byte lanes.
    assign unused_s = &{1'b0, io_read_strobe, io_address};

    assign region_s = get_region(io_address);
    assign addr_s   = 21'(io_address[ADDR_W+1:2]);
    assign hit_s    = (io_address[BRG_MATCH_HI:BRG_MATCH_LO] == BRG_BASE[BRG_MATCH_HI:BRG_MATCH_LO])
                   && ({30'd0, region_s} < 32'(N_CS));

    // Region decode for the incoming address.
    always_comb begin
        cs_dec_s = '0;
        for (int k = 0; k < N_CS; k++) begin
            cs_dec_s[k] = (region_s == 2'(k));
        end
    end

    // Selected slave's ready and read data; b_cs_r is one-hot while a slave is being accessed.
    always_comb begin
        rd_sel_s = 32'd0;
        for (int k = 0; k < N_CS; k++) begin
            rd_sel_s = rd_sel_s | ({32{b_cs_r[k]}} & b_rd_data[32*k +: 32]);
        end
    end
    assign ready_sel_s = |(b_ready & b_cs_r);

`ifdef MCS_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt_r, tmo_cnt_s;

    // Counts cycles spent in ACCESS/WAIT; zero on every other state so each access starts fresh.
    always_comb begin
        if (state_r == ACCESS || state_r == WAIT) begin
            tmo_cnt_s = tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_s = 16'd0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= 16'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    assign timeout_s = (tmo_cnt_r == 16'(TIMEOUT));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic; slave ready beats the timeout in the same cycle.
    always_comb begin
        state_s        = state_r;
        b_cs_s         = b_cs_r;
        b_wr_s         = 1'b0;
        b_rd_s         = 1'b0;
        b_be_s         = b_be_r;
        b_addr_s       = b_addr_r;
        b_wr_data_s    = b_wr_data_r;
        write_s        = write_r;
        io_ready_s     = 1'b0;
        io_read_data_s = 32'd0;
        err_set_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (io_addr_strobe && hit_s) begin
                    state_s     = ACCESS;
                    b_cs_s      = cs_dec_s;
                    b_wr_s      = io_write_strobe;
                    b_rd_s      = ~io_write_strobe;
                    b_be_s      = io_byte_enable;
                    b_addr_s    = addr_s;
                    b_wr_data_s = io_write_data;
                    write_s     = io_write_strobe;
                end else if (io_addr_strobe) begin
                    state_s    = RESP;
                    io_ready_s = 1'b1;
                    err_set_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS, WAIT: begin
                if (ready_sel_s) begin
                    state_s        = RESP;
                    b_cs_s         = '0;
                    io_ready_s     = 1'b1;
                    io_read_data_s = write_r ? 32'd0 : rd_sel_s;
                end else if (timeout_s) begin
                    state_s        = RESP;
                    b_cs_s         = '0;
                    io_ready_s     = 1'b1;
                    io_read_data_s = TIMEOUT_DATA;
                    err_set_s      = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                b_cs_s  = '0;
            end
        endcase

        if (err_set_s) begin
            bus_err_s = 1'b1;
        end else if (err_clr) begin
            bus_err_s = 1'b0;
        end else begin
            bus_err_s = bus_err_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            b_cs_r         <= '0;
            b_wr_r         <= 1'b0;
            b_rd_r         <= 1'b0;
            b_be_r         <= 4'd0;
            b_addr_r       <= 21'd0;
            b_wr_data_r    <= 32'd0;
            write_r        <= 1'b0;
            io_ready_r     <= 1'b0;
            io_read_data_r <= 32'd0;
            bus_err_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            b_cs_r         <= b_cs_s;
            b_wr_r         <= b_wr_s;
            b_rd_r         <= b_rd_s;
            b_be_r         <= b_be_s;
            b_addr_r       <= b_addr_s;
            b_wr_data_r    <= b_wr_data_s;
            write_r        <= write_s;
            io_ready_r     <= io_ready_s;
            io_read_data_r <= io_read_data_s;
            bus_err_r      <= bus_err_s;
        end
    end

    assign b_cs         = b_cs_r;
    assign b_wr         = b_wr_r;
    assign b_rd         = b_rd_r;
    assign b_be         = b_be_r;
    assign b_addr       = b_addr_r;
    assign b_wr_data    = b_wr_data_r;
    assign io_ready     = io_ready_r;
    assign io_read_data = io_read_data_r;
    assign bus_err      = bus_err_r;

endmodule

// File: tb/tb_mcs_bridge_nx.sv
// Self-checking bench for mcs_bridge_nx: directed scenarios plus randomized transactions vs a latency/data model.
module tb_mcs_bridge_nx;

    localparam int          N_CS     = 2;
    localparam int          ADDR_W   = 21;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] BRG_BASE = 32'hc000_0000;
`ifdef MCS_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]         io_byte_enable;
    logic [31:0]        io_address, io_write_data, io_read_data;
    logic               io_ready;
    logic [N_CS-1:0]    b_cs;
    logic               b_wr, b_rd;
    logic [3:0]         b_be;
    logic [20:0]        b_addr;
    logic [31:0]        b_wr_data;
    logic [32*N_CS-1:0] b_rd_data;
    logic [N_CS-1:0]    b_ready;
    logic               bus_err, err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent run_txn call
    int              obs_rc, obs_cs_cycles, obs_pulses;
    logic [31:0]     obs_rdata, obs_wdata1;
    logic            obs_err, obs_wr1, obs_rd1, obs_leak;
    logic [N_CS-1:0] obs_cs1;
    logic [20:0]     obs_addr1;
    logic [3:0]      obs_be1;

    mcs_bridge_nx #(
        .BRG_BASE(BRG_BASE), .N_CS(N_CS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .b_cs(b_cs), .b_wr(b_wr), .b_rd(b_rd), .b_be(b_be), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_rd_data(b_rd_data), .b_ready(b_ready),
        .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Issue one access from IDLE (called at a negedge) and act as the slave; delay<0 means never ready.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic both,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdata);
        int              region;
        logic [N_CS-1:0] sel;
        region = int'(addr[23:22]);
        sel = '0;
        if (region < N_CS) sel[region] = 1'b1;
        io_address = addr; io_write_strobe = we; io_read_strobe = ~we | both;
        io_byte_enable = be; io_write_data = wdata; io_addr_strobe = 1'b1;
        b_ready = N_CS'($urandom);
        @(negedge clk);
        io_addr_strobe = 1'b0; io_write_strobe = 1'b0; io_read_strobe = 1'b0;
        obs_rc = 0; obs_cs_cycles = 0; obs_pulses = 0; obs_leak = 1'b0;
        obs_rdata = 32'd0; obs_err = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 1) begin
                obs_cs1 = b_cs; obs_wr1 = b_wr; obs_rd1 = b_rd;
                obs_addr1 = b_addr; obs_be1 = b_be; obs_wdata1 = b_wr_data;
            end
            if (b_cs != '0) obs_cs_cycles++;
            if (b_wr || b_rd) obs_pulses++;
            if (io_ready) begin
                obs_rc = c; obs_rdata = io_read_data; obs_err = bus_err;
                break;
            end
            if (io_read_data != 32'd0) obs_leak = 1'b1;
            for (int k = 0; k < N_CS; k++) b_rd_data[32*k +: 32] = $urandom;
            if (region < N_CS) b_rd_data[32*region +: 32] = rdata;
            b_ready = N_CS'($urandom) & ~sel;
            if (delay >= 0 && c >= 1 + delay) b_ready = b_ready | sel;
            @(negedge clk);
        end
        b_ready = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({io_read_data, io_ready, b_cs, b_wr, b_rd, b_be, b_addr, b_wr_data, bus_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({io_ready, b_cs, b_wr, b_rd, bus_err} !== '0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b required 0", {io_ready, b_cs, b_wr, b_rd, bus_err});
        end
    endtask

    task automatic test_write;
        run_txn(32'hC000_0010, 1'b1, 1'b0, 4'b1111, 32'h1234_5678, 0, 32'hFFFF_FFFF);
        n_checks++; if (obs_cs1 !== 2'b01) begin n_fail++; $display("FAIL wr_cs: got %b required 01", obs_cs1); end
        n_checks++; if ({obs_wr1, obs_rd1} !== 2'b10) begin n_fail++; $display("FAIL wr_pulse: got %b required 10", {obs_wr1, obs_rd1}); end
        n_checks++; if (obs_addr1 !== 21'd4) begin n_fail++; $display("FAIL wr_addr: got %h required 4", obs_addr1); end
        n_checks++; if (obs_wdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_data: got %h required 12345678", obs_wdata1); end
        n_checks++; if (obs_be1 !== 4'b1111) begin n_fail++; $display("FAIL wr_be: got %b required 1111", obs_be1); end
        n_checks++; if (obs_rc !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d required 2", obs_rc); end
        n_checks++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL wr_rdata: got %h required 0", obs_rdata); end
    endtask

    task automatic test_wait_read;
        run_txn(32'hC040_0008, 1'b0, 1'b0, 4'b1111, 32'd0, 5, 32'hA5A5_0001);
        n_checks++; if (obs_cs1 !== 2'b10) begin n_fail++; $display("FAIL rd_cs: got %b required 10", obs_cs1); end
        n_checks++; if (obs_rd1 !== 1'b1) begin n_fail++; $display("FAIL rd_pulse: got %b required 1", obs_rd1); end
        n_checks++; if (obs_cs_cycles !== 6) begin n_fail++; $display("FAIL rd_cs_hold: got %0d required 6", obs_cs_cycles); end
        n_checks++; if (obs_pulses !== 1) begin n_fail++; $display("FAIL rd_pulse_count: got %0d required 1", obs_pulses); end
        n_checks++; if (obs_rc !== 7) begin n_fail++; $display("FAIL rd_latency: got %0d required 7", obs_rc); end
        n_checks++; if (obs_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_data: got %h required a5a50001", obs_rdata); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b required 0", obs_err); end
    endtask

    task automatic test_miss;
        logic [31:0] addrs [2];
        addrs[0] = 32'h8000_0000;
        addrs[1] = 32'hC0C0_0000;
        for (int i = 0; i < 2; i++) begin
            run_txn(addrs[i], 1'b0, 1'b0, 4'hF, 32'd0, 0, 32'h1111_1111);
            n_checks++; if (obs_rc !== 1) begin n_fail++; $display("FAIL miss_latency[%0d]: got %0d required 1", i, obs_rc); end
            n_checks++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL miss_data[%0d]: got %h required 0", i, obs_rdata); end
            n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL miss_err[%0d]: got %b required 1", i, obs_err); end
            n_checks++; if (obs_cs_cycles + obs_pulses !== 0) begin n_fail++; $display("FAIL miss_bus_idle[%0d]: got %0d required 0", i, obs_cs_cycles + obs_pulses); end
            n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL miss_sticky[%0d]: got %b required 1", i, bus_err); end
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_clr[%0d]: got %b required 0", i, bus_err); end
        end
        err_clr = 1'b1;
        run_txn(32'h1234_5678, 1'b1, 1'b0, 4'hF, 32'd0, 0, 32'd0);
        err_clr = 1'b0;
        n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b required 1", obs_err); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL clr_after_set: got %b required 0", bus_err); end
    endtask

    task automatic test_timeout;
        run_txn(32'hC000_0004, 1'b0, 1'b0, 4'hF, 32'd0, -1, 32'h7777_0000);
        n_checks++; if (obs_rc !== TIMEOUT + 2) begin n_fail++; $display("FAIL tmo_latency: got %0d required %0d", obs_rc, TIMEOUT + 2); end
        n_checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_data: got %h required deadbeef", obs_rdata); end
        n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b required 1", obs_err); end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        run_txn(32'hC000_0004, 1'b0, 1'b0, 4'hF, 32'd0, TIMEOUT, 32'h7777_0008);
        n_checks++; if (obs_rc !== TIMEOUT + 2) begin n_fail++; $display("FAIL limit_latency: got %0d required %0d", obs_rc, TIMEOUT + 2); end
        n_checks++; if (obs_rdata !== 32'h7777_0008) begin n_fail++; $display("FAIL limit_data: got %h required 77770008", obs_rdata); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL limit_err: got %b required 0", obs_err); end
    endtask

    task automatic test_long_wait;
        run_txn(32'hC040_0000, 1'b0, 1'b0, 4'hF, 32'd0, 20, 32'h4242_4242);
        n_checks++; if (obs_rc !== 22) begin n_fail++; $display("FAIL long_latency: got %0d required 22", obs_rc); end
        n_checks++; if (obs_rdata !== 32'h4242_4242) begin n_fail++; $display("FAIL long_data: got %h required 42424242", obs_rdata); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL long_err: got %b required 0", obs_err); end
    endtask

    task automatic test_ignore_strobe;
        int extra = 0;
        io_address = 32'hC000_0020; io_read_strobe = 1'b1; io_write_strobe = 1'b0;
        io_byte_enable = 4'h3; io_write_data = 32'd0; io_addr_strobe = 1'b1; b_ready = '0;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
        @(negedge clk);
        io_address = 32'hC040_0100; io_write_strobe = 1'b1; io_byte_enable = 4'hC;
        io_write_data = 32'h5555_AAAA; io_addr_strobe = 1'b1;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
        n_checks++;
        if ({b_cs, b_wr, b_rd, b_be, b_addr, b_wr_data, io_ready} !== {2'b01, 1'b0, 1'b0, 4'h3, 21'd8, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL ignore_bus: got cs=%b wr=%b rd=%b be=%h addr=%h wd=%h rdy=%b required cs=01 be=3 addr=8 rest 0",
                               b_cs, b_wr, b_rd, b_be, b_addr, b_wr_data, io_ready);
        end
        b_ready = 2'b01; b_rd_data = {32'h0, 32'h0BAD_F00D};
        @(negedge clk);
        b_ready = '0;
        n_checks++;
        if ({io_ready, io_read_data} !== {1'b1, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL ignore_resp: got rdy=%b data=%h required 1 0badf00d", io_ready, io_read_data);
        end
        repeat (4) begin
            @(negedge clk);
            if (io_ready || b_cs != '0 || b_wr) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_queue: got %0d active cycles required 0", extra); end
    endtask

    task automatic test_reset_mid;
        int rdy = 0;
        io_address = 32'hC040_0040; io_read_strobe = 1'b1; io_write_strobe = 1'b0; io_addr_strobe = 1'b1; b_ready = '0;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({io_read_data, io_ready, b_cs, b_wr, b_rd, b_be, b_addr, b_wr_data, bus_err} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got nonzero outputs, required all 0");
        end
        @(negedge clk);
        if (io_ready) rdy++;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (io_ready) rdy++;
        end
        n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL midreset_no_ready: got %0d required 0", rdy); end
        run_txn(32'hC000_0100, 1'b0, 1'b0, 4'hF, 32'd0, 0, 32'h600D_CAFE);
        n_checks++;
        if ({obs_rc, obs_rdata, obs_cs1} !== {32'd2, 32'h600D_CAFE, 2'b01}) begin
            n_fail++; $display("FAIL midreset_next: got rc=%0d data=%h cs=%b required 2 600dcafe 01", obs_rc, obs_rdata, obs_cs1);
        end
    endtask

    task automatic test_random;
        logic [31:0]     addr, wdata, rdata, exp_rd;
        logic            we, both, hit, tmo, exp_err;
        logic [3:0]      be;
        logic [N_CS-1:0] exp_cs1;
        int              delay, exp_rc, region;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        exp_err = 1'b0;
        for (int t = 0; t < 40; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[31:24] = 8'hC0;
            we = 1'($urandom); both = 1'($urandom); be = 4'($urandom);
            wdata = $urandom; rdata = $urandom;
            delay = int'($urandom_range(0, TO_EN ? TIMEOUT + 3 : 6));
            if (TO_EN && $urandom_range(0, 4) == 0) delay = -1;
            region = int'(addr[23:22]);
            hit = (addr[31:24] == BRG_BASE[31:24]) && (region < N_CS);
            tmo = hit && TO_EN && (delay < 0 || delay > TIMEOUT);
            exp_rc  = !hit ? 1 : (tmo ? TIMEOUT + 2 : delay + 2);
            exp_rd  = tmo ? 32'hDEAD_BEEF : ((!hit || we) ? 32'd0 : rdata);
            exp_err = exp_err | !hit | tmo;
            exp_cs1 = '0;
            if (hit) exp_cs1[region] = 1'b1;
            run_txn(addr, we, both, be, wdata, delay, rdata);
            n_checks++; if (obs_rc !== exp_rc) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", t, obs_rc, exp_rc); end
            n_checks++; if (obs_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h required %h", t, obs_rdata, exp_rd); end
            n_checks++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b required %b", t, obs_err, exp_err); end
            n_checks++; if (obs_cs1 !== exp_cs1) begin n_fail++; $display("FAIL rnd_cs[%0d]: got %b required %b", t, obs_cs1, exp_cs1); end
            n_checks++;
            if ({obs_wr1, obs_rd1} !== {hit & we, hit & ~we}) begin
                n_fail++; $display("FAIL rnd_dir[%0d]: got %b required %b", t, {obs_wr1, obs_rd1}, {hit & we, hit & ~we});
            end
            n_checks++; if (obs_pulses !== (hit ? 1 : 0)) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got %0d required %0d", t, obs_pulses, hit ? 1 : 0); end
            n_checks++; if (obs_cs_cycles !== (hit ? exp_rc - 1 : 0)) begin n_fail++; $display("FAIL rnd_cs_hold[%0d]: got %0d required %0d", t, obs_cs_cycles, hit ? exp_rc - 1 : 0); end
            n_checks++; if (obs_leak !== 1'b0) begin n_fail++; $display("FAIL rnd_rdata_idle[%0d]: got nonzero read data outside response, required 0", t); end
            if (hit) begin
                n_checks++;
                if ({obs_addr1, obs_be1, obs_wdata1} !== {21'((addr >> 2) & ((32'd1 << ADDR_W) - 32'd1)), be, wdata}) begin
                    n_fail++; $display("FAIL rnd_fields[%0d]: got addr=%h be=%h wd=%h required addr=%h be=%h wd=%h", t,
                                       obs_addr1, obs_be1, obs_wdata1, (addr >> 2) & ((32'd1 << ADDR_W) - 32'd1), be, wdata);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; err_clr = 1'b0;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_byte_enable = 4'd0; io_address = 32'd0; io_write_data = 32'd0;
        b_ready = '0; b_rd_data = '0;
        test_reset;
        test_write;
        test_wait_read;
        test_miss;
`ifdef MCS_BRIDGE_TIMEOUT_EN
        test_timeout;
`else
        test_long_wait;
`endif
        test_ignore_strobe;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
